// File: rtl/tpu_seq_ctrl.sv
// Global TPU sequencer: loops over tiles, chaining NUM_LOAD load stages, compute and an
// optional store stage, with a per-phase watchdog, abort and completion/error reporting.
module tpu_seq_ctrl #(
  parameter int NUM_LOAD    = 2,
  parameter int TILE_W      = 8,
  parameter int TIMEOUT_W   = 16,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic [TILE_W-1:0]   num_tiles_i,
  input  logic                store_en_i,
  input  logic                abort_i,
  output logic [NUM_LOAD-1:0] load_start_o,
  input  logic [NUM_LOAD-1:0] load_done_i,
  output logic                compute_start_o,
  input  logic                compute_done_i,
  output logic                store_start_o,
  input  logic                store_done_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                error_o,
  output logic [TILE_W-1:0]   tile_idx_o,
  output logic [2:0]          phase_o
);

  localparam int SW = (NUM_LOAD > 1) ? $clog2(NUM_LOAD) : 1;
  localparam logic [SW-1:0] LAST_STAGE = SW'(NUM_LOAD - 1);
  localparam logic [TIMEOUT_W-1:0] WD_LAST = TIMEOUT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_COMPUTE = 3'd2,
    ST_STORE   = 3'd3,
    ST_FINISH  = 3'd4,
    ST_ERR     = 3'd5
  } state_e;

  state_e                state_q, state_d;
  logic [SW-1:0]         stage_q, stage_d;
  logic [TILE_W-1:0]     tile_q, tile_d;
  logic [TILE_W-1:0]     ntiles_q, ntiles_d;
  logic                  store_en_q, store_en_d;
  logic [TIMEOUT_W-1:0]  wd_q, wd_d;
  logic [NUM_LOAD-1:0]   ld_start_q, ld_start_d;
  logic                  cs_q, cs_d;
  logic                  ss_q, ss_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  tile_end;
  logic                  wd_hit;
  logic [TILE_W:0]       tile_nxt;

  assign wd_hit   = (TIMEOUT_CYC != 0) && (wd_q == WD_LAST);
  assign tile_nxt = {1'b0, tile_q} + (TILE_W+1)'(1);

  // Handshake: every *_start_o is a one-cycle pulse; the matching *_done_i pulse is
  // honoured only in the waiting state, never in the same cycle as its own start pulse.
  always_comb begin
    state_d    = state_q;
    stage_d    = stage_q;
    tile_d     = tile_q;
    ntiles_d   = ntiles_q;
    store_en_d = store_en_q;
    wd_d       = wd_q;
    err_d      = err_q;
    ld_start_d = '0;
    cs_d       = 1'b0;
    ss_d       = 1'b0;
    tile_end   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          ntiles_d   = num_tiles_i;
          store_en_d = store_en_i;
          err_d      = 1'b0;
          tile_d     = '0;
          stage_d    = '0;
          wd_d       = '0;
          if (num_tiles_i == '0) begin
            state_d = ST_FINISH;
          end else begin
            state_d    = ST_LOAD;
            ld_start_d = NUM_LOAD'(1);
          end
        end
      end
      ST_LOAD, ST_COMPUTE, ST_STORE: begin
        wd_d = wd_q + TIMEOUT_W'(1);
        if (abort_i) begin
          state_d = ST_IDLE;
        end else if (wd_hit) begin
          state_d = ST_ERR;
          err_d   = 1'b1;
        end else if (state_q == ST_LOAD) begin
          if (load_done_i[stage_q] && !ld_start_q[stage_q]) begin
            wd_d = '0;
            if (stage_q == LAST_STAGE) begin
              state_d = ST_COMPUTE;
              cs_d    = 1'b1;
            end else begin
              stage_d    = stage_q + SW'(1);
              ld_start_d = NUM_LOAD'(1) << stage_d;
            end
          end
        end else if (state_q == ST_COMPUTE) begin
          if (compute_done_i && !cs_q) begin
            if (store_en_q) begin
              state_d = ST_STORE;
              ss_d    = 1'b1;
              wd_d    = '0;
            end else begin
              tile_end = 1'b1;
            end
          end
        end else begin
          if (store_done_i && !ss_q) tile_end = 1'b1;
        end
        if (tile_end) begin
          if (tile_nxt < {1'b0, ntiles_q}) begin
            tile_d     = tile_nxt[TILE_W-1:0];
            stage_d    = '0;
            state_d    = ST_LOAD;
            ld_start_d = NUM_LOAD'(1);
            wd_d       = '0;
          end else begin
            state_d = ST_FINISH;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_LOAD) || (state_d == ST_COMPUTE) || (state_d == ST_STORE);
    done_d = (state_d == ST_FINISH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      stage_q    <= '0;
      tile_q     <= '0;
      ntiles_q   <= '0;
      store_en_q <= 1'b0;
      wd_q       <= '0;
      ld_start_q <= '0;
      cs_q       <= 1'b0;
      ss_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      stage_q    <= stage_d;
      tile_q     <= tile_d;
      ntiles_q   <= ntiles_d;
      store_en_q <= store_en_d;
      wd_q       <= wd_d;
      ld_start_q <= ld_start_d;
      cs_q       <= cs_d;
      ss_q       <= ss_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign load_start_o    = ld_start_q;
  assign compute_start_o = cs_q;
  assign store_start_o   = ss_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign error_o         = err_q;
  assign tile_idx_o      = tile_q;
  assign phase_o         = state_q;

endmodule

// File: tb/tb_tpu_seq_ctrl.sv
// Bench for tpu_seq_ctrl: responders return done pulses after a latency, a model predicts
// every start/done pulse with its cycle and tile, and a monitor compares them in order.
module tb_tpu_seq_ctrl;
  localparam int NUM_LOAD = 2;
  localparam int TILE_W   = 8;
  localparam int TMO      = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_i = 1'b0;
  logic [TILE_W-1:0] num_tiles_i = '0;
  logic store_en_i = 1'b0;
  logic abort_i = 1'b0;
  logic [NUM_LOAD-1:0] load_start_o, load_done_i;
  logic compute_start_o, compute_done_i, store_start_o, store_done_i;
  logic busy_o, done_o, error_o;
  logic [TILE_W-1:0] tile_idx_o;
  logic [2:0] phase_o;

  logic [NUM_LOAD-1:0] resp_ld = '0, extra_ld = '0;
  logic resp_cd = 1'b0, resp_sd = 1'b0, extra_cd = 1'b0;
  assign load_done_i    = resp_ld | extra_ld;
  assign compute_done_i = resp_cd | extra_cd;
  assign store_done_i   = resp_sd;

  int lat = 3;
  bit ld_en = 1'b1, cd_en = 1'b1;
  int cyc = 0;
  int t0 = 0;
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  tpu_seq_ctrl #(.NUM_LOAD(NUM_LOAD), .TILE_W(TILE_W), .TIMEOUT_W(16), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .num_tiles_i(num_tiles_i),
    .store_en_i(store_en_i), .abort_i(abort_i), .load_start_o(load_start_o),
    .load_done_i(load_done_i), .compute_start_o(compute_start_o),
    .compute_done_i(compute_done_i), .store_start_o(store_start_o),
    .store_done_i(store_done_i), .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
    .tile_idx_o(tile_idx_o), .phase_o(phase_o)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc - t0);
    end
  endtask

  function automatic logic [31:0] ev(input int rel, input int tile, input int kind);
    logic [15:0] r;
    logic [7:0]  t;
    logic [3:0]  k;
    r = 16'(rel);
    t = 8'(tile);
    k = 4'(kind);
    return {r, t, 4'h0, k};
  endfunction

  // kinds: 0..NUM_LOAD-1 load stage, 8 compute, 9 store, 10 done
  function automatic void push_model(input int nt, input bit se, input int l);
    int t = 1;
    for (int ti = 0; ti < nt; ti++) begin
      for (int s = 0; s < NUM_LOAD; s++) begin
        exp_q.push_back(ev(t, ti, s));
        t += l + 1;
      end
      exp_q.push_back(ev(t, ti, 8));
      t += l + 1;
      if (se) begin
        exp_q.push_back(ev(t, ti, 9));
        t += l + 1;
      end
    end
    exp_q.push_back(ev(t, (nt > 0) ? nt - 1 : 0, 10));
  endfunction

  task automatic observe(input int kind);
    logic [31:0] obs;
    obs = ev(cyc - t0, int'(tile_idx_o), kind);
    if (exp_q.size() == 0) check("unexpected_event", obs, 32'hFFFF_FFFF);
    else check("event", obs, exp_q.pop_front());
  endtask

  // scoreboard monitor
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int s = 0; s < NUM_LOAD; s++) if (load_start_o[s]) observe(s);
        if (compute_start_o) observe(8);
        if (store_start_o) observe(9);
        if (done_o) observe(10);
      end
    end
  end

  // done responders
  initial begin
    int ld_cnt [NUM_LOAD];
    int cd_cnt, sd_cnt;
    for (int s = 0; s < NUM_LOAD; s++) ld_cnt[s] = 0;
    cd_cnt = 0;
    sd_cnt = 0;
    forever begin
      @(negedge clk);
      for (int s = 0; s < NUM_LOAD; s++) begin
        resp_ld[s] = (ld_cnt[s] == 1);
        if (ld_cnt[s] > 0) ld_cnt[s]--;
      end
      resp_cd = (cd_cnt == 1);
      if (cd_cnt > 0) cd_cnt--;
      resp_sd = (sd_cnt == 1);
      if (sd_cnt > 0) sd_cnt--;
      if (rst_n) begin
        for (int s = 0; s < NUM_LOAD; s++) if (load_start_o[s] && ld_en) ld_cnt[s] = lat;
        if (compute_start_o && cd_en) cd_cnt = lat;
        if (store_start_o) sd_cnt = lat;
      end
    end
  end

  // driver tasks
  task automatic wait_rel(input int n);
    while (cyc - t0 < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_run(input int nt, input bit se);
    num_tiles_i = TILE_W'(nt);
    store_en_i  = se;
    start_i     = 1'b1;
    t0          = cyc;
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(tag, exp_q.size(), 0);
    exp_q.delete();
    repeat (8) @(posedge clk);
    #1;
  endtask

  initial begin
    int l2;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {load_start_o, compute_start_o, store_start_o, busy_o, done_o,
                            error_o, tile_idx_o, phase_o}, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // single tile, no store; busy window and FINISH phase
    lat = 3;
    push_model(1, 1'b0, 3);
    start_run(1, 1'b0);
    for (int r = 1; r <= 14; r++) begin
      @(negedge clk);
      check("s1_busy", busy_o, (r <= 12) ? 1 : 0);
      if (r == 13) check("s1_phase_finish", phase_o, 4);
    end
    drain("s1_drain", 40);

    // zero tiles
    push_model(0, 1'b0, 3);
    start_run(0, 1'b0);
    @(negedge clk);
    check("s3_phase", phase_o, 4);
    check("s3_busy", busy_o, 0);
    @(negedge clk);
    check("s3_idle", phase_o, 0);
    drain("s3_drain", 10);

    // three tiles with store, random latency
    l2 = $urandom_range(1, 5);
    lat = l2;
    push_model(3, 1'b1, l2);
    start_run(3, 1'b1);
    drain("s2_drain", 200);
    check("s2_tile_hold", tile_idx_o, 2);
    lat = 3;

    // watchdog: stage 0 never completes
    ld_en = 1'b0;
    exp_q.push_back(ev(1, 0, 0));
    start_run(1, 1'b0);
    for (int r = 1; r <= 18; r++) begin
      @(negedge clk);
      if (r == 16) check("s4_pre_err", phase_o, 1);
      if (r == 17) begin
        check("s4_phase_err", phase_o, 5);
        check("s4_error", error_o, 1);
        check("s4_busy", busy_o, 0);
      end
      if (r == 18) check("s4_sticky", {phase_o, error_o}, {3'd0, 1'b1});
    end
    ld_en = 1'b1;
    drain("s4_drain", 10);
    check("s4_error_held", error_o, 1);

    // stray load_done[1] and start while busy; error clears on accept
    push_model(1, 1'b0, 3);
    start_run(1, 1'b0);
    @(negedge clk);
    check("s6_error_cleared", error_o, 0);
    wait_rel(2);
    extra_ld = 2'b10;
    wait_rel(3);
    extra_ld = '0;
    start_i  = 1'b1;
    wait_rel(4);
    start_i  = 1'b0;
    drain("s6_drain", 40);

    // abort during compute, late compute_done ignored
    cd_en = 1'b0;
    exp_q.push_back(ev(1, 0, 0));
    exp_q.push_back(ev(5, 0, 1));
    exp_q.push_back(ev(9, 0, 8));
    start_run(1, 1'b0);
    wait_rel(11);
    abort_i = 1'b1;
    @(negedge clk);
    check("s5_in_compute", phase_o, 2);
    wait_rel(12);
    abort_i = 1'b0;
    @(negedge clk);
    check("s5_abort", {phase_o, busy_o, done_o}, 0);
    wait_rel(14);
    extra_cd = 1'b1;
    wait_rel(15);
    extra_cd = 1'b0;
    drain("s5_drain", 20);
    check("s5_still_idle", {phase_o, busy_o}, 0);
    cd_en = 1'b1;

    // reset mid-run
    exp_q.push_back(ev(1, 0, 0));
    start_run(2, 1'b1);
    wait_rel(3);
    rst_n = 1'b0;
    #1;
    check("midrun_reset", {load_start_o, compute_start_o, store_start_o, busy_o, done_o,
                           error_o, tile_idx_o, phase_o}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    drain("reset_drain", 5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
